// File: rtl/shift_unit_iter.sv
// Multi-cycle iterative shifter (LSL/LSR/ASR/ROR) with ARM-exact carry behaviour.
// Shifts up to STEP positions per cycle under a start/busy/done handshake.
module shift_unit_iter #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             S,
    input  logic [1:0]       stype,
    input  logic [WIDTH-1:0] Rm,
    input  logic [AMT_W-1:0] amount,
    input  logic             carry_in,
    input  logic             zero_in,
    input  logic             neg_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Rd,
    output logic             carry_out,
    output logic             zero_out,
    output logic             neg_out
);

    localparam int CNT_W = $clog2(WIDTH + 2);
    localparam int EXT_W = (AMT_W > CNT_W) ? AMT_W : CNT_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    localparam logic [EXT_W-1:0] LIM_LOGIC = EXT_W'(WIDTH + 1);
    localparam logic [EXT_W-1:0] LIM_ASR   = EXT_W'(WIDTH);
    localparam logic [CNT_W-1:0] STEP_C    = CNT_W'(STEP);

    logic [1:0]       state_q;
    logic [WIDTH-1:0] work_q;
    logic [1:0]       op_q;
    logic             s_q;
    logic             sign_q;
    logic             c_acc_q;
    logic             c_in_q;
    logic             z_in_q;
    logic             n_in_q;
    logic [CNT_W-1:0] rem_q;

    logic [EXT_W-1:0] amt_ext;
    logic [EXT_W-1:0] eff_ext;
    logic [CNT_W-1:0] eff_cnt;
    logic             c_load;
    logic [CNT_W-1:0] step_cnt;
    logic [WIDTH-1:0] nxt_work;
    logic             nxt_c;
    logic             start_ok;
    logic             last_step;
    logic             finish;
    logic [WIDTH-1:0] fin_rd;
    logic             fin_c;
    logic             fin_s;
    logic             fin_cf;
    logic             fin_zf;
    logic             fin_nf;

    assign busy = (state_q == ST_SHIFT);
    assign done = (state_q == ST_DONE);

    // Effective count: logical shifts saturate one past WIDTH so the carry
    // can still fall to zero, ASR saturates at WIDTH, ROR wraps.
    always_comb begin
        amt_ext = EXT_W'(amount);
        eff_ext = amt_ext;
        case (stype)
            OP_LSL, OP_LSR: if (amt_ext > LIM_LOGIC) eff_ext = LIM_LOGIC;
            OP_ASR:         if (amt_ext > LIM_ASR)   eff_ext = LIM_ASR;
            default:        eff_ext = amt_ext % LIM_ASR;
        endcase
        eff_cnt = CNT_W'(eff_ext);
        c_load  = carry_in;
        if (stype == OP_ROR && amount != '0 && eff_cnt == '0)
            c_load = Rm[WIDTH-1];
    end

    assign step_cnt = (rem_q < STEP_C) ? rem_q : STEP_C;

    always_comb begin
        nxt_work = work_q;
        nxt_c    = c_acc_q;
        for (int i = 0; i < STEP; i++) begin
            if (CNT_W'(i) < step_cnt) begin
                case (op_q)
                    OP_LSL: begin
                        nxt_c    = nxt_work[WIDTH-1];
                        nxt_work = {nxt_work[WIDTH-2:0], 1'b0};
                    end
                    OP_LSR: begin
                        nxt_c    = nxt_work[0];
                        nxt_work = {1'b0, nxt_work[WIDTH-1:1]};
                    end
                    OP_ASR: begin
                        nxt_c    = nxt_work[0];
                        nxt_work = {sign_q, nxt_work[WIDTH-1:1]};
                    end
                    default: begin
                        nxt_c    = nxt_work[0];
                        nxt_work = {nxt_work[0], nxt_work[WIDTH-1:1]};
                    end
                endcase
            end
        end
    end

    assign start_ok  = (state_q == ST_IDLE) && start;
    assign last_step = (state_q == ST_SHIFT) && (rem_q <= STEP_C);
    assign finish    = (start_ok && (eff_cnt == '0)) || last_step;

    // A zero-count operation finishes straight from the live inputs.
    always_comb begin
        fin_rd = nxt_work;
        fin_c  = nxt_c;
        fin_s  = s_q;
        fin_cf = c_in_q;
        fin_zf = z_in_q;
        fin_nf = n_in_q;
        if (state_q == ST_IDLE) begin
            fin_rd = Rm;
            fin_c  = c_load;
            fin_s  = S;
            fin_cf = carry_in;
            fin_zf = zero_in;
            fin_nf = neg_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            op_q    <= OP_LSL;
            s_q     <= 1'b0;
            sign_q  <= 1'b0;
            c_acc_q <= 1'b0;
            c_in_q  <= 1'b0;
            z_in_q  <= 1'b0;
            n_in_q  <= 1'b0;
            rem_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        work_q  <= Rm;
                        op_q    <= stype;
                        s_q     <= S;
                        sign_q  <= Rm[WIDTH-1];
                        c_acc_q <= c_load;
                        c_in_q  <= carry_in;
                        z_in_q  <= zero_in;
                        n_in_q  <= neg_in;
                        rem_q   <= eff_cnt;
                        state_q <= (eff_cnt == '0) ? ST_DONE : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    work_q  <= nxt_work;
                    c_acc_q <= nxt_c;
                    rem_q   <= rem_q - step_cnt;
                    if (last_step) state_q <= ST_DONE;
                end
                ST_DONE:  state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    // Result and flags are registered on entry to DONE and held afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Rd        <= '0;
            carry_out <= 1'b0;
            zero_out  <= 1'b0;
            neg_out   <= 1'b0;
        end else if (finish) begin
            Rd <= fin_rd;
            if (fin_s) begin
                carry_out <= fin_c;
                zero_out  <= (fin_rd == '0);
                neg_out   <= fin_rd[WIDTH-1];
            end else begin
                carry_out <= fin_cf;
                zero_out  <= fin_zf;
                neg_out   <= fin_nf;
            end
        end
    end

endmodule

// File: tb/tb_shift_unit_iter.sv
// Directed bench for shift_unit_iter: a STEP=1 and a STEP=4 instance share stimulus
// and are checked against hand-computed results, latencies and control behaviour.
module tb_shift_unit_iter;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sFlag;
    logic [1:0]  stype;
    logic [31:0] rm;
    logic [7:0]  amount;
    logic        carryIn;
    logic        zeroIn;
    logic        negIn;

    logic        busyA, doneA, cA, zA, nA;
    logic [31:0] rdA;
    logic        busyB, doneB, cB, zB, nB;
    logic [31:0] rdB;

    int testsRun  = 0;
    int failCount = 0;
    int doneCountA = 0;
    int doneCountB = 0;
    int savedA;
    int savedB;

    shift_unit_iter #(.WIDTH(32), .AMT_W(8), .STEP(1)) dutA (
        .clk(clk), .rst(rst), .start(start), .S(sFlag), .stype(stype),
        .Rm(rm), .amount(amount), .carry_in(carryIn), .zero_in(zeroIn),
        .neg_in(negIn), .busy(busyA), .done(doneA), .Rd(rdA),
        .carry_out(cA), .zero_out(zA), .neg_out(nA)
    );

    shift_unit_iter #(.WIDTH(32), .AMT_W(8), .STEP(4)) dutB (
        .clk(clk), .rst(rst), .start(start), .S(sFlag), .stype(stype),
        .Rm(rm), .amount(amount), .carry_in(carryIn), .zero_in(zeroIn),
        .neg_in(negIn), .busy(busyB), .done(doneB), .Rd(rdB),
        .carry_out(cB), .zero_out(zB), .neg_out(nB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Done pulses are tallied mid-cycle so each one-cycle pulse counts once.
    always @(negedge clk) begin
        if (doneA) doneCountA++;
        if (doneB) doneCountB++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Issue one operation, scramble the inputs while busy, then measure latency
    // (cycle k+N with k the accepting edge) and check the held results.
    task automatic applyStimulus(input string tag, input logic [1:0] op,
                                 input logic [31:0] rmVal, input logic [7:0] amt,
                                 input logic sVal, input logic cIn, input logic zIn,
                                 input logic nIn, input int expLatA, input int expLatB,
                                 input logic [31:0] expRd, input logic expC,
                                 input logic expZ, input logic expN);
        int cyc;
        int latA;
        int latB;
        @(negedge clk);
        stype   = op;
        rm      = rmVal;
        amount  = amt;
        sFlag   = sVal;
        carryIn = cIn;
        zeroIn  = zIn;
        negIn   = nIn;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        stype   = ~op;
        rm      = ~rmVal;
        amount  = amt ^ 8'h55;
        sFlag   = ~sVal;
        carryIn = ~cIn;
        zeroIn  = ~zIn;
        negIn   = ~nIn;
        latA = 0;
        latB = 0;
        cyc  = 1;
        while (cyc < 100) begin
            if (doneA && latA == 0) latA = cyc;
            if (doneB && latB == 0) latB = cyc;
            if (latA != 0 && latB != 0) break;
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput({tag, "_latA"}, latA, expLatA);
        checkOutput({tag, "_latB"}, latB, expLatB);
        checkOutput({tag, "_rdA"}, rdA, expRd);
        checkOutput({tag, "_rdB"}, rdB, expRd);
        checkOutput({tag, "_flagsA_czn"}, {29'd0, cA, zA, nA}, {29'd0, expC, expZ, expN});
        checkOutput({tag, "_flagsB_czn"}, {29'd0, cB, zB, nB}, {29'd0, expC, expZ, expN});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b0;
        start   = 1'b0;
        sFlag   = 1'b0;
        stype   = 2'b00;
        rm      = '0;
        amount  = '0;
        carryIn = 1'b0;
        zeroIn  = 1'b0;
        negIn   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ctrlA", {30'd0, busyA, doneA}, 32'd0);
        checkOutput("reset_ctrlB", {30'd0, busyB, doneB}, 32'd0);
        checkOutput("reset_rdA", rdA, 32'd0);
        checkOutput("reset_flagsA", {29'd0, cA, zA, nA}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        applyStimulus("lsl1",     2'b00, 32'h8000_0001, 8'd1,   1, 0, 0, 0, 2,  2,  32'h0000_0002, 1, 0, 0);
        applyStimulus("asr4",     2'b10, 32'h8000_00F0, 8'd4,   1, 0, 0, 0, 5,  2,  32'hF800_000F, 0, 0, 1);
        applyStimulus("lsr32",    2'b01, 32'h8000_0000, 8'd32,  1, 0, 0, 0, 33, 9,  32'h0000_0000, 1, 1, 0);
        applyStimulus("lsr33",    2'b01, 32'h8000_0000, 8'd33,  1, 1, 0, 0, 34, 10, 32'h0000_0000, 0, 1, 0);
        applyStimulus("lsl200",   2'b00, 32'hFFFF_FFFF, 8'd200, 1, 1, 0, 1, 34, 10, 32'h0000_0000, 0, 1, 0);
        applyStimulus("ror1",     2'b11, 32'h0000_0001, 8'd1,   1, 0, 0, 0, 2,  2,  32'h8000_0000, 1, 0, 1);
        applyStimulus("ror64",    2'b11, 32'h0000_0001, 8'd64,  1, 1, 0, 0, 1,  1,  32'h0000_0001, 0, 0, 0);
        applyStimulus("n0_s1",    2'b00, 32'h0000_0000, 8'd0,   1, 1, 0, 0, 1,  1,  32'h0000_0000, 1, 1, 0);
        applyStimulus("n0_s0",    2'b00, 32'h0000_0000, 8'd0,   0, 1, 0, 0, 1,  1,  32'h0000_0000, 1, 0, 0);
        applyStimulus("lsr4_s0",  2'b01, 32'h0000_00F0, 8'd4,   0, 0, 1, 1, 5,  2,  32'h0000_000F, 0, 1, 1);
        applyStimulus("asr40",    2'b10, 32'h8000_0000, 8'd40,  1, 0, 0, 0, 33, 9,  32'hFFFF_FFFF, 1, 0, 1);

        // Reset asserted while both instances are mid-shift.
        @(negedge clk);
        stype  = 2'b00;
        rm     = 32'h0000_0003;
        amount = 8'd20;
        sFlag  = 1'b1;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("midrst_busy_before", {30'd0, busyA, busyB}, 32'd3);
        savedA = doneCountA;
        savedB = doneCountB;
        rst = 1'b0;
        #1;
        checkOutput("midrst_ctrl", {28'd0, busyA, doneA, busyB, doneB}, 32'd0);
        checkOutput("midrst_rdA", rdA, 32'd0);
        checkOutput("midrst_rdB", rdB, 32'd0);
        checkOutput("midrst_flags", {26'd0, cA, zA, nA, cB, zB, nB}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        checkOutput("midrst_no_doneA", doneCountA - savedA, 32'd0);
        checkOutput("midrst_no_doneB", doneCountB - savedB, 32'd0);

        // A second start while busy must be dropped.
        savedA = doneCountA;
        savedB = doneCountB;
        @(negedge clk);
        stype  = 2'b00;
        rm     = 32'h0000_0001;
        amount = 8'd8;
        sFlag  = 1'b1;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rm     = 32'h0000_DEAD;
        amount = 8'd2;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("busystart_donesA", doneCountA - savedA, 32'd1);
        checkOutput("busystart_donesB", doneCountB - savedB, 32'd1);
        checkOutput("busystart_rdA", rdA, 32'h0000_0100);
        checkOutput("busystart_rdB", rdB, 32'h0000_0100);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
